icache_param: RTL and testbench
===============================

# icache_param

Parametrised direct-mapped instruction cache sitting between the datapath fetch port and the memory controller's instruction channel. It serves hits combinationally from a SETS × WORDS array, fills a full block on a miss through the iREN/iwait/iload handshake, and supports a bulk invalidate. It also keeps saturating hit/miss counters for performance reporting. It is the successor to the single-cycle pass-through fetch path with its one-word instruction holding register.

## Interface
Parameters:
- SETS, 16, number of lines; power of 2, ≥2
- WORDS, 2, 32-bit words per block; power of 2, ≥1

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous reset, active-high
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address; [1:0] ignored
- ihit  out  1  requested word valid this cycle
- imemload  out  32  instruction word
- iREN  out  1  memory read request
- iaddr  out  32  memory word address, [1:0]=00
- iwait  in  1  memory busy; low = iload valid this cycle
- iload  in  32  memory read data
- flush  in  1  invalidate all lines (level, sampled each edge)
- hit_count  out  16  saturating hit counter
- miss_count  out  16  saturating miss counter

## Operation
- Address split: BO=log2(WORDS) block-offset bits at [2+:BO]; IX=log2(SETS) index bits above them; tag = remaining upper 30-BO-IX bits.
- Per line: valid bit, tag, WORDS data words.
- FSM states:
  - IDLE
    - ihit = imemREN & valid[ix] & tag match & !flush.
    - imemload = data[ix][bo] whenever valid and tag match; '0 otherwise.
    - On imemREN & !hit & !flush: latch tag/index, clear word counter k, increment miss_count, go to FILL.
    - On flush: clear all valid bits at the edge; stay in IDLE.
  - FILL
    - iREN=1; iaddr={latched tag, latched index, k, 2'b00}; ihit=0.
    - On !iwait: write iload into data[index][k]; k++.
    - When k=WORDS-1 and !iwait: write tag and set valid; go to IDLE.
- Fill always starts at word 0 and runs to completion, even if imemREN drops or imemaddr changes mid-fill.
- flush asserted during FILL sets flush_pending. At fill completion the word and tag are written, then all valid bits (including the new line) are cleared. flush_pending is cleared on that edge.
- hit_count increments on every IDLE cycle with ihit=1.
- Both counters saturate at 16'hFFFF.
- A miss replaces the indexed line unconditionally (direct-mapped; no write-back).
- Only CLK edges change state. RST clears: all valid bits, state=IDLE, k=0, flush_pending=0, both counters=0.
- Data and tag arrays are not reset.

## Timing
- Outputs after reset: ihit=0, iREN=0, iaddr=0, imemload=0, hit_count=0, miss_count=0.
- Hit: combinational, same cycle as the request, 0 wait states.
- Miss: the miss cycle detects and enters FILL; iREN rises on the next cycle.
- The fill takes WORDS handshakes, each lasting its iwait-high cycles plus 1.
- One IDLE cycle after the fill yields ihit for the original address.
- Miss latency with iwait high for W cycles per word = 1 + WORDS·(W+1) cycles before ihit.
- iaddr advances to the next word the cycle after each !iwait. iREN stays high across words with no bubble.
- RST asserted mid-fill: next edge forces IDLE and iREN=0. The partially filled line stays invalid.
- flush and a hit in the same IDLE cycle: ihit=0, no hit counted. Next cycle misses.
- SETS/WORDS not a power of 2: elaboration error.

## Test plan
- Cold miss, SETS=16, WORDS=2, iwait high 2 cycles per word, fetch 0x0000_0040 -> iaddr 0x40 then 0x44; ihit at cycle 7 with iload word 0; miss_count=1.
- Hit after fill: fetch 0x44 then 0x40 -> both ihit same cycle with 0 wait; iREN stays 0; hit_count=2.
- Conflict: fetch 0x40, then 0x0000_00C0 (same index, different tag), then 0x40 -> three fills; miss_count=3.
- Flush during FILL of 0x40, then fetch 0x40 -> fill completes, line invalidated; second fetch misses again; miss_count=2.
- RST held 1 cycle mid-fill after word 0 -> iREN=0 next cycle; counters 0; fetch 0x40 refills from word 0.
- Saturation: 65 540 consecutive hits -> hit_count holds 16'hFFFF; no wrap to 0.

Source files
------------

// File: rtl/icache_param_if.sv
// Fetch-side and memory-side signals of the parametrised instruction cache.
// The cache uses the slave view; whatever drives it uses the master view.
interface icache_param_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        flush;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, iwait, iload, flush,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, iwait, iload, flush,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_param.sv
// Direct-mapped instruction cache: serves hits combinationally, fills whole blocks on a miss,
// supports bulk invalidate, and keeps saturating hit/miss counters.
//   state | meaning
//   IDLE  | serve hits, detect misses, apply flush
//   FILL  | fetch WORDS words of the latched block from memory
module icache_param #(
  parameter int SETS  = 16,
  parameter int WORDS = 2
) (
  input logic           CLK,
  input logic           RST,
  icache_param_if.slave cif
);
  localparam int IX  = $clog2(SETS);
  localparam int BO  = $clog2(WORDS);
  localparam int BOW = (BO > 0) ? BO : 1;
  localparam int TW  = 30 - BO - IX;

  if (SETS < 2 || (1 << IX) != SETS) begin : g_bad_sets
    $error("icache_param: SETS must be a power of 2 and at least 2");
  end
  if (WORDS < 1 || (1 << BO) != WORDS) begin : g_bad_words
    $error("icache_param: WORDS must be a power of 2 and at least 1");
  end

  typedef enum logic {IDLE, FILL} state_t;
  state_t state_q, state_d;

  logic [31:0]     data_q [SETS][WORDS];
  logic [TW-1:0]   tag_q  [SETS];
  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   fill_tag_q;
  logic [IX-1:0]   fill_ix_q;
  logic [BOW-1:0]  k_q;
  logic            flush_pend_q;
  logic [15:0]     hit_cnt_q;
  logic [15:0]     miss_cnt_q;

  logic [TW-1:0]   req_tag;
  logic [IX-1:0]   req_ix;
  logic [BOW-1:0]  req_bo;
  logic [31:0]     fill_addr;
  logic            match;
  logic            hit;
  logic            miss;
  logic            word_done;
  logic            last_word;

  assign req_tag = cif.imemaddr[31 -: TW];
  assign req_ix  = cif.imemaddr[2+BO +: IX];

  if (BO > 0) begin : g_bo
    assign req_bo    = cif.imemaddr[2 +: BO];
    assign fill_addr = {fill_tag_q, fill_ix_q, k_q, 2'b00};
  end else begin : g_no_bo
    assign req_bo    = '0;
    assign fill_addr = {fill_tag_q, fill_ix_q, 2'b00};
  end

  assign match     = valid_q[req_ix] && (tag_q[req_ix] == req_tag);
  assign word_done = (state_q == FILL) && !cif.iwait;
  assign last_word = (k_q == BOW'(WORDS - 1));

  always_comb begin
    state_d      = state_q;
    hit          = 1'b0;
    miss         = 1'b0;
    cif.ihit     = 1'b0;
    cif.imemload = '0;
    cif.iREN     = 1'b0;
    cif.iaddr    = '0;
    case (state_q)
      IDLE: begin
        hit      = cif.imemREN && match && !cif.flush;
        miss     = cif.imemREN && !match && !cif.flush;
        cif.ihit = hit;
        if (match) cif.imemload = data_q[req_ix][req_bo];
        if (miss) state_d = FILL;
      end
      FILL: begin
        cif.iREN  = 1'b1;
        cif.iaddr = fill_addr;
        if (word_done && last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      k_q          <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (miss && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      if (state_q == IDLE) begin
        if (cif.flush) begin
          valid_q <= '0;
        end else if (miss) begin
          valid_q[req_ix] <= 1'b0;
          k_q             <= '0;
        end
      end else begin
        if (cif.flush) flush_pend_q <= 1'b1;
        if (word_done) begin
          k_q <= last_word ? '0 : k_q + 1'b1;
          // A flush seen at any point of the fill also discards the line just completed.
          if (last_word) begin
            flush_pend_q <= 1'b0;
            if (flush_pend_q || cif.flush) valid_q <= '0;
            else valid_q[fill_ix_q] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (miss) begin
      fill_tag_q <= req_tag;
      fill_ix_q  <= req_ix;
    end
    if (word_done) data_q[fill_ix_q][k_q] <= cif.iload;
    if (word_done && last_word) tag_q[fill_ix_q] <= fill_tag_q;
  end

  assign cif.hit_count  = hit_cnt_q;
  assign cif.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_icache_param.sv
// Self-checking bench for icache_param: table vectors, hand-written corner sequences,
// and randomized fetches compared against a block-level cache model.
module tb_icache_param;
  localparam int SETS  = 16;
  localparam int WORDS = 2;
  localparam int BLK_BYTES = 4 * WORDS;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  icache_param_if cif();

  icache_param #(.SETS(SETS), .WORDS(WORDS)) dut (
    .CLK (CLK),
    .RST (RST),
    .cif (cif)
  );

  always #5 CLK = ~CLK;

  int nchk = 0;
  int nerr = 0;
  int mem_w = 0;
  logic [31:0] served_q[$];

  // Reference model: which block number each set holds, plus event counts.
  logic [31:0] ref_blk [SETS];
  bit          ref_vld [SETS];
  int          ref_hits;
  int          ref_miss;

  typedef struct {
    logic [31:0] addr;
    int          w;
    int          exp_lat;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    return wa * 32'h9E37_79B1 + 32'h7F4A_7C15;
  endfunction

  function automatic logic [31:0] sat16(input int n);
    return (n > 65535) ? 32'h0000_FFFF : 32'(n);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Memory: holds iwait high for mem_w cycles per word, then presents the word for one cycle.
  initial begin
    int wc;
    wc = 0;
    cif.iwait = 1'b1;
    cif.iload = 32'hDEAD_BEEF;
    forever begin
      @(posedge CLK);
      #1;
      if (cif.iREN) begin
        if (wc < mem_w) begin
          cif.iwait = 1'b1;
          cif.iload = 32'hDEAD_BEEF;
          wc++;
        end else begin
          cif.iwait = 1'b0;
          cif.iload = mem_word(cif.iaddr);
          served_q.push_back(cif.iaddr);
          wc = 0;
        end
      end else begin
        cif.iwait = 1'b1;
        cif.iload = 32'hDEAD_BEEF;
        wc = 0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic ref_reset();
    for (int s = 0; s < SETS; s++) ref_vld[s] = 1'b0;
    ref_hits = 0;
    ref_miss = 0;
  endtask

  task automatic ref_access(input logic [31:0] a, input int w, output int exp_lat);
    logic [31:0] blk;
    int s;
    blk = a / BLK_BYTES;
    s   = int'(blk % SETS);
    if (ref_vld[s] && ref_blk[s] == blk) begin
      exp_lat = 0;
    end else begin
      exp_lat = 1 + WORDS * (w + 1);
      ref_miss++;
      ref_vld[s] = 1'b1;
      ref_blk[s] = blk;
    end
    ref_hits++;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cif.imemREN  = 1'b0;
    cif.imemaddr = 32'h0000_0040;
    cif.flush    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Holds the request until ihit; lat counts the cycles before the ihit cycle.
  task automatic fetch(input logic [31:0] a, input int w, output int lat,
                       output logic [31:0] d, output bit ok);
    lat = 0;
    ok  = 1'b0;
    d   = '0;
    mem_w = w;
    cif.imemaddr = a;
    cif.imemREN  = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (cif.ihit) begin
        d  = cif.imemload;
        ok = 1'b1;
        break;
      end
      lat++;
    end
    @(posedge CLK);
    #1;
    cif.imemREN = 1'b0;
  endtask

  task automatic check_fetch(input string nm, input logic [31:0] a, input int w, input int exp_lat);
    int lat;
    logic [31:0] d;
    logic [31:0] base;
    bit ok;
    served_q.delete();
    fetch(a, w, lat, d, ok);
    chk({nm, "_ihit_seen"}, 32'(ok), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_data"}, d, mem_word(a));
    base = a & ~32'(BLK_BYTES - 1);
    if (exp_lat != 0) begin
      chk({nm, "_fill_words"}, 32'(served_q.size()), 32'(WORDS));
      for (int j = 0; j < WORDS && j < served_q.size(); j++)
        chk($sformatf("%s_iaddr%0d", nm, j), served_q[j], base + 32'(4 * j));
    end else begin
      chk({nm, "_no_fill"}, 32'(served_q.size()), 32'd0);
    end
  endtask

  task automatic wait_fill_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (!cif.iREN) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_fill_done"}, 32'(ok), 32'd1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int exp_hits;
    int exp_miss;

    tbl[0] = '{32'h0000_0040, 2, 7};
    tbl[1] = '{32'h0000_0044, 0, 0};
    tbl[2] = '{32'h0000_0040, 0, 0};
    tbl[3] = '{32'h0000_00C0, 0, 3};
    tbl[4] = '{32'h0000_0040, 1, 5};
    tbl[5] = '{32'h0000_0048, 0, 3};
    tbl[6] = '{32'h0000_004C, 3, 0};
    tbl[7] = '{32'h0000_0044, 0, 0};
    tbl[8] = '{32'h1000_0040, 0, 3};
    tbl[9] = '{32'h0000_0040, 0, 3};

    do_reset();
    @(negedge CLK);
    chk("reset_ihit", 32'(cif.ihit), 32'd0);
    chk("reset_iREN", 32'(cif.iREN), 32'd0);
    chk("reset_iaddr", cif.iaddr, 32'd0);
    chk("reset_imemload", cif.imemload, 32'd0);
    chk("reset_hit_count", 32'(cif.hit_count), 32'd0);
    chk("reset_miss_count", 32'(cif.miss_count), 32'd0);
    @(posedge CLK);
    #1;

    // Table vectors: every fetch ends in one ihit cycle, misses add one miss each.
    exp_hits = 0;
    exp_miss = 0;
    for (int i = 0; i < 10; i++) begin
      check_fetch($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].w, tbl[i].exp_lat);
      exp_hits++;
      if (tbl[i].exp_lat != 0) exp_miss++;
    end
    chk("tbl_hit_count", 32'(cif.hit_count), 32'(exp_hits));
    chk("tbl_miss_count", 32'(cif.miss_count), 32'(exp_miss));

    // Flush while a fill is in progress: the fill completes but the line is discarded.
    do_reset();
    served_q.delete();
    mem_w = 2;
    cif.imemaddr = 32'h0000_0040;
    cif.imemREN  = 1'b1;
    @(posedge CLK);
    #1;
    cif.imemREN = 1'b0;
    @(posedge CLK);
    #1;
    cif.flush = 1'b1;
    @(posedge CLK);
    #1;
    cif.flush = 1'b0;
    wait_fill_done("flushfill");
    chk("flushfill_words", 32'(served_q.size()), 32'(WORDS));
    check_fetch("flushfill_refetch", 32'h0000_0040, 2, 7);
    chk("flushfill_miss_count", 32'(cif.miss_count), 32'd2);
    chk("flushfill_hit_count", 32'(cif.hit_count), 32'd1);

    // Flush coinciding with a would-be hit: no hit, and the next cycle misses.
    cif.imemaddr = 32'h0000_0040;
    cif.imemREN  = 1'b1;
    cif.flush    = 1'b1;
    @(negedge CLK);
    chk("flushhit_ihit", 32'(cif.ihit), 32'd0);
    @(posedge CLK);
    #1;
    cif.flush = 1'b0;
    @(negedge CLK);
    chk("flushhit_next_ihit", 32'(cif.ihit), 32'd0);
    chk("flushhit_hit_count", 32'(cif.hit_count), 32'd1);
    chk("flushhit_miss_count", 32'(cif.miss_count), 32'd2);
    @(posedge CLK);
    #1;
    cif.imemREN = 1'b0;
    wait_fill_done("flushhit");
    chk("flushhit_miss_after", 32'(cif.miss_count), 32'd3);

    // Reset after word 0 of a fill: iREN drops, counters clear, refetch starts at word 0.
    do_reset();
    mem_w = 1;
    cif.imemaddr = 32'h0000_0040;
    cif.imemREN  = 1'b1;
    @(posedge CLK);
    #1;
    cif.imemREN = 1'b0;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rstfill_iREN", 32'(cif.iREN), 32'd0);
    chk("rstfill_iaddr", cif.iaddr, 32'd0);
    chk("rstfill_hit_count", 32'(cif.hit_count), 32'd0);
    chk("rstfill_miss_count", 32'(cif.miss_count), 32'd0);
    @(posedge CLK);
    #1;
    check_fetch("rstfill_refetch", 32'h0000_0040, 0, 3);

    // Randomized fetches and occasional flushes against the block-level model.
    do_reset();
    ref_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        cif.flush = 1'b1;
        @(posedge CLK);
        #1;
        cif.flush = 1'b0;
        for (int s = 0; s < SETS; s++) ref_vld[s] = 1'b0;
      end else begin
        logic [31:0] a;
        int w;
        int exp_lat;
        a = 32'($urandom_range(0, 95)) * 32'd4;
        if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
        w = $urandom_range(0, 3);
        ref_access(a, w, exp_lat);
        check_fetch($sformatf("rnd%0d", i), a, w, exp_lat);
      end
    end
    chk("rnd_hit_count", 32'(cif.hit_count), sat16(ref_hits));
    chk("rnd_miss_count", 32'(cif.miss_count), sat16(ref_miss));

    // Saturation: 65540 hits in total on one resident line.
    do_reset();
    check_fetch("sat_fill", 32'h0000_0040, 0, 3);
    cif.imemaddr = 32'h0000_0040;
    cif.imemREN  = 1'b1;
    repeat (65533) @(posedge CLK);
    #1;
    chk("sat_before", 32'(cif.hit_count), sat16(1 + 65533));
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    chk("sat_ihit", 32'(cif.ihit), 32'd1);
    chk("sat_hold", 32'(cif.hit_count), sat16(1 + 65533 + 6));
    chk("sat_miss_count", 32'(cif.miss_count), 32'd1);
    cif.imemREN = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
